// File: rtl/mdr_mar_mem_port.sv
// MAR/MDR register pair with a req/ack memory port; bus loads in IDLE, one
// outstanding read or write at a time, with wait-cycle timeout.
module mdr_mar_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mdr_q    <= '0;
      mar_q    <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // MAR loads even alongside a start, so the access sees the new address
          if (MARin) mar_q <= bus_in[ADDR_W-1:0];
          if (MDRin && Read) begin
            state    <= S_RD_WAIT;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_err  <= 1'b0;
            wait_cnt <= '0;
          end else begin
            if (MDRin) mdr_q <= bus_in;
            if (Write) begin
              state    <= S_WR_WAIT;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_err  <= 1'b0;
              wait_cnt <= '0;
            end
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (mem_ack) begin
            if (state == S_RD_WAIT) mdr_q <= mem_rdata;
            state   <= S_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state   <= S_ERR;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mdr_mar_mem_port.sv
// Directed bench for mdr_mar_mem_port: bus loads, read/write handshakes,
// timeout, busy-time input blocking, read/write conflict and mid-op clear.
module tb_mdr_mar_mem_port;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] bus_in = '0;
  logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [31:0] mdr_q;
  logic [8:0]  mar_q;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, mem_err;

  int total = 0;
  int bad   = 0;

  mdr_mar_mem_port #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
    .clk(clk), .clear(clear), .bus_in(bus_in),
    .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
    .mdr_q(mdr_q), .mar_q(mar_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    chk("rst_mdr", mdr_q, 32'h0);
    chk("rst_mar", {23'b0, mar_q}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, mem_err}, 32'h0);

    // plain bus loads
    bus_in = 32'h0000_0123; MARin = 1'b1;
    step();
    MARin = 1'b0;
    chk("ld_req0", {31'b0, mem_req}, 32'h0);
    bus_in = 32'hDEAD_BEEF; MDRin = 1'b1;
    step();
    MDRin = 1'b0;
    chk("ld_mar", {23'b0, mar_q}, 32'h123);
    chk("ld_mdr", mdr_q, 32'hDEAD_BEEF);
    chk("ld_req1", {31'b0, mem_req}, 32'h0);
    chk("ld_done", {31'b0, done}, 32'h0);
    chk("ld_busy", {31'b0, busy}, 32'h0);

    // read, memory acks on first wait cycle
    bus_in = 32'h0000_002A; MARin = 1'b1;
    step();
    MARin = 1'b0;
    MDRin = 1'b1; Read = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0;
    chk("rd_req", {31'b0, mem_req}, 32'h1);
    chk("rd_we", {31'b0, mem_we}, 32'h0);
    chk("rd_addr", {23'b0, mem_addr}, 32'h02A);
    chk("rd_busy", {31'b0, busy}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rd_done", {31'b0, done}, 32'h1);
    chk("rd_mdr", mdr_q, 32'h55);
    chk("rd_req_off", {31'b0, mem_req}, 32'h0);
    step();
    chk("rd_done_off", {31'b0, done}, 32'h0);
    chk("rd_idle", {31'b0, busy}, 32'h0);

    // write with ack after 4 wait cycles
    bus_in = 32'hCAFE_0001; MDRin = 1'b1;
    step();
    MDRin = 1'b0;
    bus_in = 32'h0000_01FF; MARin = 1'b1;
    step();
    MARin = 1'b0;
    Write = 1'b1;
    step();
    Write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_req", {31'b0, mem_req}, 32'h1);
      chk("wr_we", {31'b0, mem_we}, 32'h1);
      chk("wr_wdata", mem_wdata, 32'hCAFE_0001);
      chk("wr_addr", {23'b0, mem_addr}, 32'h1FF);
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("wr_done", {31'b0, done}, 32'h1);
    chk("wr_req_off", {31'b0, mem_req}, 32'h0);
    step();
    chk("wr_done_off", {31'b0, done}, 32'h0);
    chk("wr_idle", {31'b0, busy}, 32'h0);

    // timeout: no ack for a read
    MDRin = 1'b1; Read = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_req", {31'b0, mem_req}, 32'h1);
      step();
    end
    chk("to_req_off", {31'b0, mem_req}, 32'h0);
    chk("to_err", {31'b0, mem_err}, 32'h1);
    chk("to_mdr", mdr_q, 32'hCAFE_0001);
    chk("to_done", {31'b0, done}, 32'h0);
    step();
    chk("to_idle", {31'b0, busy}, 32'h0);
    chk("to_err_sticky", {31'b0, mem_err}, 32'h1);
    MDRin = 1'b1; Read = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0;
    chk("to_err_clr", {31'b0, mem_err}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("to_rd_mdr", mdr_q, 32'h1234_5678);
    chk("to_rd_done", {31'b0, done}, 32'h1);
    step();

    // inputs ignored while busy
    MDRin = 1'b1; Read = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0;
    bus_in = 32'hFFFF_FFFF; MARin = 1'b1; MDRin = 1'b1; Write = 1'b1;
    step();
    step();
    chk("bz_mar", {23'b0, mar_q}, 32'h1FF);
    chk("bz_mdr", mdr_q, 32'h1234_5678);
    chk("bz_we", {31'b0, mem_we}, 32'h0);
    MARin = 1'b0; MDRin = 1'b0; Write = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("bz_mdr_rd", mdr_q, 32'hA5A5_A5A5);
    chk("bz_done", {31'b0, done}, 32'h1);
    step();
    step();
    chk("bz_no_second", {31'b0, mem_req}, 32'h0);
    chk("bz_idle", {31'b0, busy}, 32'h0);

    // read and write together: read wins
    bus_in = 32'h0; MDRin = 1'b1; Read = 1'b1; Write = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    chk("cf_req", {31'b0, mem_req}, 32'h1);
    chk("cf_we", {31'b0, mem_we}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("cf_mdr", mdr_q, 32'h0BAD_F00D);
    step();

    // clear during the second write wait cycle
    Write = 1'b1;
    step();
    Write = 1'b0;
    step();
    chk("cl_pre_req", {31'b0, mem_req}, 32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("cl_req", {31'b0, mem_req}, 32'h0);
    chk("cl_we", {31'b0, mem_we}, 32'h0);
    chk("cl_mdr", mdr_q, 32'h0);
    chk("cl_mar", {23'b0, mar_q}, 32'h0);
    chk("cl_busy", {31'b0, busy}, 32'h0);
    chk("cl_err", {31'b0, mem_err}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    chk("late_ack_done", {31'b0, done}, 32'h0);
    chk("late_ack_mdr", mdr_q, 32'h0);
    chk("late_ack_busy", {31'b0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_mar_mem_port.md
Name: mdr_mar_mem_port

Overview:
- Memory-side stage directly downstream of the datapath bus mux and upstream of its MDR input.
- Holds the MAR and MDR registers and loads both from the 32-bit bus.
- Runs a req/ack handshake with the external memory for Read and Write control steps.
- Returns the MDR contents to the bus mux on mdr_q (drives BusMuxInMDR).

Parameters:
- DATA_W, 32, data width of the bus, MDR and memory data.
- ADDR_W, 9, MAR width; memory word address.
- TIMEOUT, 15, maximum memory wait cycles without ack before abort (must be ≥1).

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
bus_in  in  DATA_W  BusMuxOut from the datapath bus
MARin  in  1  load MAR from bus_in[ADDR_W-1:0]
MDRin  in  1  load MDR (source chosen by Read)
Read  in  1  with MDRin: start memory read into MDR
Write  in  1  start memory write of MDR to mem[MAR]
mdr_q  out  DATA_W  MDR contents, drives BusMuxInMDR
mar_q  out  ADDR_W  MAR contents
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  equals mar_q
mem_wdata  out  DATA_W  equals mdr_q
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  memory completion, one cycle
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse on successful completion
mem_err  out  1  timeout flag, sticky

Behaviour:
- Reset (clear=1 at a clk edge, overrides all other inputs): mdr_q=0, mar_q=0, mem_req=0, mem_we=0, done=0, mem_err=0, state=IDLE. Mid-transaction clear abandons the transaction; mem_req is low in the cycle after that edge.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE, ERR. All outputs are registered.
- IDLE:
  - MARin=1 → mar_q <= bus_in[ADDR_W-1:0].
  - MDRin=1, Read=0 → mdr_q <= bus_in. No memory access.
  - MDRin=1, Read=1 → RD_WAIT; mem_req<=1, mem_we<=0; mem_err<=0; wait counter <= 0.
  - Write=1 (and not a read start) → WR_WAIT; mem_req<=1, mem_we<=1; mem_err<=0; counter <= 0.
  - Read start and Write in the same cycle: the read wins and the write is dropped.
  - MARin together with a start in the same cycle: MAR loads at that edge, so the access uses the new address.
- RD_WAIT / WR_WAIT:
  - mem_ack sampled each cycle.
  - On ack in RD_WAIT: mdr_q <= mem_rdata, then go to DONE.
  - On ack in WR_WAIT: go to DONE; memory captures mem_wdata on the ack cycle.
  - No ack: counter+1. If counter==TIMEOUT-1 without ack → ERR. A request therefore waits at most TIMEOUT cycles.
  - MARin, MDRin, Read and Write are ignored; mar_q and mdr_q are frozen (except the read-data capture).
- DONE: mem_req=0, done=1 for exactly one cycle, then IDLE. Inputs are ignored.
- ERR: mem_req=0, mem_err=1, mdr_q unchanged, then IDLE. mem_err stays 1 until clear or the next accepted start.
- mem_ack outside the wait states is ignored.
- Latency: start sampled at edge N → mem_req=1 from N+1. Ack at edge N+k (k≥1) → done=1 and new mdr_q visible during cycle N+k+1. Next command accepted at edge N+k+2.
- busy = (state != IDLE).
- mem_addr and mem_wdata are continuous copies of mar_q and mdr_q.

Test Plan:
- Bus loads: bus_in=0x0000_0123 with MARin=1, then bus_in=0xDEAD_BEEF with MDRin=1, Read=0 → mar_q=0x123, mdr_q=0xDEADBEEF, mem_req never asserted, done=0.
- Read, 1-cycle memory: MAR=0x02A, start read, memory acks on the first wait cycle with rdata=0x0000_0055 → mem_req high for 1 cycle with mem_we=0 and mem_addr=0x02A; mdr_q=0x55 and done=1 exactly 2 cycles after the start edge.
- Write with wait states: MDR=0xCAFE_0001, MAR=0x1FF, pulse Write, ack delayed 4 cycles → mem_req/mem_we high 4 cycles with wdata=0xCAFE0001; done pulses once; busy low afterwards.
- Timeout: start a read with TIMEOUT=15 and never ack → mem_req high exactly 15 cycles, then mem_err=1, mdr_q unchanged. A following successful read clears mem_err.
- Busy-time and conflict inputs: during RD_WAIT drive MARin, MDRin and Write with bus_in=0xFFFF_FFFF → mar_q and mdr_q unchanged, no second transaction. Read+Write asserted together in IDLE → a read only (mem_we=0).
- Reset mid-op: assert clear during WR_WAIT cycle 2 → the next cycle has all outputs 0 and state IDLE. A late mem_ack afterwards is ignored (done stays 0).
